serial_frame_receiver: RTL and testbench
========================================

Name: serial_frame_receiver

Overview:
- Downstream stage of the Exp3 serial transmitter top level; consumes its 1-bit `out` line.
- Detects a start bit and samples each bit at mid-bit, MSB first.
- Deserialises DATA_W data bits, checks the stop bit, and presents the parallel word with a one-cycle valid strobe, an error strobe and a frame counter.
- Used for loop-back checking of the transmitter on the board (received word shown on LEDs).

Parameters:
- DATA_W, 10, data bits per frame.
- BIT_CYCLES, 4, clock cycles per serial bit; legal range 1..255.
- CNT_W, 8, width of frame_cnt.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  receiver enable; low forces IDLE and aborts any frame in progress.
- si  in  1  serial line, synchronous to clk. Idle level is 0.
- rx_data  out  DATA_W  last correctly received word.
- rx_valid  out  1  one-cycle pulse when rx_data is updated.
- frame_err  out  1  one-cycle pulse when the stop bit is bad.
- busy  out  1  high in any state other than IDLE.
- frame_cnt  out  CNT_W  count of good frames; wraps from 2^CNT_W-1 to 0.

Behaviour:
- Frame format: idle 0, start bit 1, DATA_W data bits MSB first, stop bit 0.
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - rx_data, rx_valid, frame_err, busy, frame_cnt and all counters are 0.
- Cycle numbering: edge 0 is the clk edge at which IDLE samples si=1. HALF = BIT_CYCLES/2 (integer division).
- Sampling points:
  - Start bit re-checked at edge HALF.
  - Data bit k (k=0 is the MSB) sampled at edge HALF+(k+1)*BIT_CYCLES.
  - Stop bit sampled at edge HALF+(DATA_W+1)*BIT_CYCLES.
- States:
  - IDLE: if en=1 and si=1, go to START with bit-cycle counter=0. If HALF=0, go directly to DATA (the edge-0 sample counts as the start confirm).
  - START: at edge HALF, si=1 goes to DATA; si=0 is a glitch and returns to IDLE with no strobes.
  - DATA: shift si into the shift register at each data sample point. After the last data bit, go to STOP.
  - STOP: at the stop sample point:
    - si=0: rx_data is loaded from the shift register, rx_valid=1 for exactly one cycle, frame_cnt increments.
    - si=1: frame_err=1 for one cycle; rx_data and frame_cnt are unchanged.
    - Either way, return to IDLE.
- Latency: rx_valid and frame_err are registered at the stop-sample edge and go high immediately after it. No extra pipeline delay.
- Back-to-back frames: IDLE may detect a new start bit at the edge right after the stop sample. There is no minimum idle gap.
- en=0 mid-frame: go to IDLE on the next edge with no strobes. The shift register content is discarded.
- en deasserted in the same edge as the stop sample: en wins; no strobes.
- rx_valid and frame_err are never high in the same cycle.
- busy is combinational from state (state != IDLE).
- frame_cnt wrap: 255 -> 0 with CNT_W=8; no saturation and no flag.
- The rx_data register holds its value until the next good frame or reset.

Decomposition:
- Shared package rx_pkg contains:
  - state enum {IDLE, START, DATA, STOP};
  - localparams for start level 1, stop level 0 and idle level 0, shared with the transmitter.
- One sub-module, rx_bit_timer:
  - counts 0..BIT_CYCLES-1;
  - takes a load input (for the HALF offset) and emits a `tick` at each sample point;
  - the FSM and shift register stay in the top block.

Test Plan:
- Good frame: DATA_W=10, BIT_CYCLES=4, word 10'b1000110101 (start at edge 0, stop at edge 46) -> rx_valid pulses at edge 46 only, rx_data=10'b1000110101, frame_cnt 0->1, frame_err stays 0.
- Glitch: si=1 for 1 cycle, then 0 -> return to IDLE by edge 2, busy high for 2 cycles, no strobes, frame_cnt unchanged.
- Bad stop: same word with stop bit 1 -> frame_err pulse at edge 46, rx_valid=0, rx_data keeps its previous value, frame_cnt unchanged.
- Abort and reset mid-frame:
  - en dropped at edge 20 -> IDLE at edge 21, no strobes.
  - Separate run: rst pulsed low at edge 30 -> all outputs 0 immediately, without waiting for clk.
- Back-to-back and wrap: 256 consecutive good frames of 10'h2A5 with zero idle gap -> 256 rx_valid pulses, each rx_data=10'h2A5, frame_cnt ends at 0.
- BIT_CYCLES=1: frame 10'b0000000001 at one bit per cycle -> start confirmed at edge 0 (HALF=0), rx_valid at edge 11, rx_data=10'b0000000001.

Source files
------------

// File: rtl/serial_frame_receiver_pkg.sv
// serial_frame_receiver_pkg: shared receiver states and serial line levels
package rx_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

    localparam logic START_LVL = 1'b1;
    localparam logic STOP_LVL  = 1'b0;
    localparam logic IDLE_LVL  = 1'b0;

endpackage

// File: rtl/serial_frame_receiver_if.sv
// serial_frame_receiver_if: serial input and parallel result bundle of the receiver
interface serial_frame_receiver_if #(
    parameter int DATA_W = 10,
    parameter int CNT_W  = 8
);

    logic              en;
    logic              si;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              frame_err;
    logic              busy;
    logic [CNT_W-1:0]  frame_cnt;

    modport master (output en, si, input rx_data, rx_valid, frame_err, busy, frame_cnt);
    modport slave  (input en, si, output rx_data, rx_valid, frame_err, busy, frame_cnt);

endinterface

// File: rtl/serial_frame_receiver_bit_timer.sv
// rx_bit_timer: bit-period counter that ticks at every mid-bit sample point
module rx_bit_timer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic tick_o
);

    // loading here makes the first tick land HALF edges after the start detect
    localparam logic [7:0] LOAD_VAL = 8'((BIT_CYCLES - BIT_CYCLES / 2) % BIT_CYCLES);

    logic [7:0] cnt_q, cnt_d;

    assign tick_o = cnt_q == 8'(BIT_CYCLES - 1);
    assign cnt_d  = load_i ? LOAD_VAL : tick_o ? 8'd0 : cnt_q + 8'd1;

    // free-running modulo-BIT_CYCLES counter, realigned on each start detect
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;

endmodule

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: start-bit framed, MSB-first serial deserialiser with stop check
module serial_frame_receiver
    import rx_pkg::*;
#(
    parameter int DATA_W     = 10,
    parameter int BIT_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic rst,
    serial_frame_receiver_if.slave bus
);

    localparam int HALF = BIT_CYCLES / 2;
    localparam int BW   = $clog2(DATA_W) + 1;

    rx_state_e         state_q;
    logic [BW-1:0]     bit_q;
    logic [DATA_W-1:0] shift_q, shift_d, rx_data_q;
    logic              rx_valid_q, frame_err_q;
    logic [CNT_W-1:0]  frame_cnt_q;
    logic              tick, load;

    assign load    = state_q == IDLE && bus.en && bus.si == START_LVL;
    assign shift_d = {shift_q[DATA_W-2:0], bus.si};

    rx_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .tick_o (tick)
    );

    // frame FSM; en low overrides everything, including a stop sample on the same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (!bus.en) state_q <= IDLE;
            else case (state_q)
                IDLE: if (bus.si == START_LVL) begin
                    state_q <= HALF == 0 ? DATA : START;
                    bit_q   <= '0;
                end
                START: if (tick) state_q <= bus.si == START_LVL ? DATA : IDLE;
                DATA: if (tick) begin
                    shift_q <= shift_d;
                    bit_q   <= bit_q + BW'(1);
                    if (bit_q == BW'(DATA_W - 1)) state_q <= STOP;
                end
                STOP: if (tick) begin
                    state_q <= IDLE;
                    if (bus.si == STOP_LVL) begin
                        rx_data_q   <= shift_q;
                        rx_valid_q  <= 1'b1;
                        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                    end else frame_err_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.busy      = state_q != IDLE;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb_serial_frame_receiver: randomized and directed checks against a frame-level timing model
module tb_serial_frame_receiver;

    localparam int D  = 10;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    serial_frame_receiver_if #(.DATA_W(D), .CNT_W(CW)) ifa ();
    serial_frame_receiver_if #(.DATA_W(D), .CNT_W(CW)) ifb ();

    serial_frame_receiver #(.DATA_W(D), .BIT_CYCLES(4), .CNT_W(CW)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    serial_frame_receiver #(.DATA_W(D), .BIT_CYCLES(1), .CNT_W(CW)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    logic [1:0]    vld, err, bsy;
    logic [D-1:0]  dat [2];
    logic [CW-1:0] cnt [2];
    assign vld    = {ifb.rx_valid, ifa.rx_valid};
    assign err    = {ifb.frame_err, ifa.frame_err};
    assign bsy    = {ifb.busy, ifa.busy};
    assign dat[0] = ifa.rx_data;
    assign dat[1] = ifb.rx_data;
    assign cnt[0] = ifa.frame_cnt;
    assign cnt[1] = ifb.frame_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [D-1:0]  exp_data [2];
    logic [CW-1:0] exp_cnt  [2];

    task automatic drive(input bit sel, input bit en_v, input bit si_v);
        if (sel) begin ifb.en = en_v; ifb.si = si_v; end
        else     begin ifa.en = en_v; ifa.si = si_v; end
    endtask

    // frame-level reference: where the strobes land and how long busy lasts
    task automatic model(input bit sel, input logic [D-1:0] w, input bit stop, input int abort_e,
                         output int xv, output int xe, output int xb);
        int bc = sel ? 1 : 4;
        int se = bc / 2 + (D + 1) * bc;
        bit ab = abort_e >= 0 && abort_e <= se;
        xv = -1;
        xe = -1;
        xb = ab ? abort_e : se;
        if (!ab) begin
            if (!stop) begin xv = se; exp_data[sel] = w; exp_cnt[sel] = exp_cnt[sel] + 1'b1; end
            else xe = se;
        end
    endtask

    // drives one frame starting at edge 0, with en low from abort_e through the stop sample, then gap idle edges
    task automatic run_frame(input bit sel, input logic [D-1:0] w, input bit stop, input int abort_e, input int gap,
                             output int v_edge, output int v_num, output int e_edge, output int e_num,
                             output int busy_n, output int both);
        int bc = sel ? 1 : 4;
        int se = bc / 2 + (D + 1) * bc;
        logic [D+1:0] fb = {1'b1, w, stop};
        v_edge = -1; v_num = 0; e_edge = -1; e_num = 0; busy_n = 0; both = 0;
        for (int e = 0; e <= se + gap; e++) begin
            drive(sel, !(abort_e >= 0 && e >= abort_e && e <= se), e <= se ? fb[D + 1 - e / bc] : 1'b0);
            @(posedge clk);
            @(negedge clk);
            if (vld[sel]) begin v_num++; if (v_edge < 0) v_edge = e; end
            if (err[sel]) begin e_num++; if (e_edge < 0) e_edge = e; end
            if (bsy[sel]) busy_n++;
            if (vld[sel] && err[sel]) both++;
        end
        drive(sel, 1'b1, 1'b0);
    endtask

    task automatic test_reset;
        drive(0, 1'b1, 1'b0);
        drive(1, 1'b1, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            n_cmp++; if (dat[s] !== '0) begin n_err++; $display("FAIL reset_data[%0d]: got %h want 0", s, dat[s]); end
            n_cmp++; if (cnt[s] !== '0) begin n_err++; $display("FAIL reset_cnt[%0d]: got %0d want 0", s, cnt[s]); end
            n_cmp++; if ({vld[s], err[s], bsy[s]} !== 3'b000) begin n_err++; $display("FAIL reset_strobes[%0d]: got %b want 000", s, {vld[s], err[s], bsy[s]}); end
        end
        rst = 1'b1;
        exp_data[0] = '0; exp_data[1] = '0; exp_cnt[0] = '0; exp_cnt[1] = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bsy !== 2'b00) begin n_err++; $display("FAIL reset_release_busy: got %b want 00", bsy); end
    endtask

    task automatic test_good_frame;
        int xv, xe, xb, ve, vn, ee, en, bn, bo;
        model(0, 10'b1000110101, 1'b0, -1, xv, xe, xb);
        run_frame(0, 10'b1000110101, 1'b0, -1, 3, ve, vn, ee, en, bn, bo);
        n_cmp++; if (ve !== 46 || ve !== xv) begin n_err++; $display("FAIL good_valid_edge: got %0d want %0d", ve, xv); end
        n_cmp++; if (vn !== 1) begin n_err++; $display("FAIL good_valid_count: got %0d want 1", vn); end
        n_cmp++; if (en !== 0) begin n_err++; $display("FAIL good_err_count: got %0d want 0", en); end
        n_cmp++; if (bn !== xb) begin n_err++; $display("FAIL good_busy_len: got %0d want %0d", bn, xb); end
        n_cmp++; if (ifa.rx_data !== 10'b1000110101) begin n_err++; $display("FAIL good_data: got %b want %b", ifa.rx_data, 10'b1000110101); end
        n_cmp++; if (ifa.frame_cnt !== 8'd1) begin n_err++; $display("FAIL good_cnt: got %0d want 1", ifa.frame_cnt); end
    endtask

    task automatic test_glitch;
        for (int e = 0; e < 5; e++) begin
            drive(0, 1'b1, e == 0);
            @(posedge clk);
            @(negedge clk);
            n_cmp++; if (ifa.busy !== (e < 2)) begin n_err++; $display("FAIL glitch_busy@%0d: got %b want %b", e, ifa.busy, e < 2); end
            n_cmp++; if (ifa.rx_valid || ifa.frame_err) begin n_err++; $display("FAIL glitch_strobe@%0d: got %b%b want 00", e, ifa.rx_valid, ifa.frame_err); end
        end
        n_cmp++; if (ifa.frame_cnt !== exp_cnt[0]) begin n_err++; $display("FAIL glitch_cnt: got %0d want %0d", ifa.frame_cnt, exp_cnt[0]); end
    endtask

    task automatic test_bad_stop;
        int xv, xe, xb, ve, vn, ee, en, bn, bo;
        model(0, 10'b1000110101, 1'b1, -1, xv, xe, xb);
        run_frame(0, 10'b1000110101, 1'b1, -1, 2, ve, vn, ee, en, bn, bo);
        n_cmp++; if (ee !== 46 || ee !== xe) begin n_err++; $display("FAIL badstop_err_edge: got %0d want %0d", ee, xe); end
        n_cmp++; if (en !== 1) begin n_err++; $display("FAIL badstop_err_count: got %0d want 1", en); end
        n_cmp++; if (vn !== 0) begin n_err++; $display("FAIL badstop_valid_count: got %0d want 0", vn); end
        n_cmp++; if (ifa.rx_data !== exp_data[0]) begin n_err++; $display("FAIL badstop_data: got %h want %h", ifa.rx_data, exp_data[0]); end
        n_cmp++; if (ifa.frame_cnt !== exp_cnt[0]) begin n_err++; $display("FAIL badstop_cnt: got %0d want %0d", ifa.frame_cnt, exp_cnt[0]); end
    endtask

    task automatic test_abort(input int a);
        int xv, xe, xb, ve, vn, ee, en, bn, bo;
        logic [D-1:0] w = D'($urandom);
        model(0, w, 1'b0, a, xv, xe, xb);
        run_frame(0, w, 1'b0, a, 2, ve, vn, ee, en, bn, bo);
        n_cmp++; if (vn + en !== 0) begin n_err++; $display("FAIL abort%0d_strobes: got %0d want 0", a, vn + en); end
        n_cmp++; if (bn !== xb) begin n_err++; $display("FAIL abort%0d_busy_len: got %0d want %0d", a, bn, xb); end
        n_cmp++; if (ifa.rx_data !== exp_data[0]) begin n_err++; $display("FAIL abort%0d_data: got %h want %h", a, ifa.rx_data, exp_data[0]); end
        n_cmp++; if (ifa.frame_cnt !== exp_cnt[0]) begin n_err++; $display("FAIL abort%0d_cnt: got %0d want %0d", a, ifa.frame_cnt, exp_cnt[0]); end
    endtask

    task automatic test_bit_cycles_1;
        int xv, xe, xb, ve, vn, ee, en, bn, bo;
        model(1, 10'b0000000001, 1'b0, -1, xv, xe, xb);
        run_frame(1, 10'b0000000001, 1'b0, -1, 2, ve, vn, ee, en, bn, bo);
        n_cmp++; if (ve !== 11 || ve !== xv) begin n_err++; $display("FAIL bc1_valid_edge: got %0d want %0d", ve, xv); end
        n_cmp++; if (vn !== 1 || en !== 0) begin n_err++; $display("FAIL bc1_strobes: got %0d/%0d want 1/0", vn, en); end
        n_cmp++; if (bn !== 11) begin n_err++; $display("FAIL bc1_busy_len: got %0d want 11", bn); end
        n_cmp++; if (ifb.rx_data !== 10'b0000000001) begin n_err++; $display("FAIL bc1_data: got %b want 0000000001", ifb.rx_data); end
        n_cmp++; if (ifb.frame_cnt !== exp_cnt[1]) begin n_err++; $display("FAIL bc1_cnt: got %0d want %0d", ifb.frame_cnt, exp_cnt[1]); end
    endtask

    task automatic test_random;
        int xv, xe, xb, ve, vn, ee, en, bn, bo;
        for (int i = 0; i < 40; i++) begin
            bit sel = 1'($urandom);
            logic [D-1:0] w = D'($urandom);
            bit stop = $urandom_range(3) == 0;
            int se = sel ? 11 : 46;
            int ab = $urandom_range(4) == 0 ? int'($urandom_range(se)) : -1;
            int gap = $urandom_range(3);
            model(sel, w, stop, ab, xv, xe, xb);
            run_frame(sel, w, stop, ab, gap, ve, vn, ee, en, bn, bo);
            n_cmp++; if (ve !== xv || vn !== (xv >= 0)) begin n_err++; $display("FAIL rand%0d_valid: got edge %0d n %0d want edge %0d", i, ve, vn, xv); end
            n_cmp++; if (ee !== xe || en !== (xe >= 0)) begin n_err++; $display("FAIL rand%0d_err: got edge %0d n %0d want edge %0d", i, ee, en, xe); end
            n_cmp++; if (bn !== xb) begin n_err++; $display("FAIL rand%0d_busy_len: got %0d want %0d", i, bn, xb); end
            n_cmp++; if (bo !== 0) begin n_err++; $display("FAIL rand%0d_both: got %0d want 0", i, bo); end
            n_cmp++; if (dat[sel] !== exp_data[sel]) begin n_err++; $display("FAIL rand%0d_data: got %h want %h", i, dat[sel], exp_data[sel]); end
            n_cmp++; if (cnt[sel] !== exp_cnt[sel]) begin n_err++; $display("FAIL rand%0d_cnt: got %0d want %0d", i, cnt[sel], exp_cnt[sel]); end
        end
    endtask

    task automatic test_async_reset;
        logic [D+1:0] fb = {1'b1, 10'h3C7, 1'b0};
        for (int e = 0; e <= 30; e++) begin
            drive(0, 1'b1, fb[D + 1 - e / 4]);
            @(posedge clk);
            @(negedge clk);
        end
        n_cmp++; if (ifa.busy !== 1'b1) begin n_err++; $display("FAIL areset_pre_busy: got %b want 1", ifa.busy); end
        rst = 1'b0;
        #1;
        n_cmp++; if (ifa.busy !== 1'b0) begin n_err++; $display("FAIL areset_busy: got %b want 0", ifa.busy); end
        n_cmp++; if (ifa.rx_data !== '0) begin n_err++; $display("FAIL areset_data: got %h want 0", ifa.rx_data); end
        n_cmp++; if (ifa.frame_cnt !== '0 || ifb.frame_cnt !== '0) begin n_err++; $display("FAIL areset_cnt: got %0d/%0d want 0/0", ifa.frame_cnt, ifb.frame_cnt); end
        n_cmp++; if (ifa.rx_valid || ifa.frame_err) begin n_err++; $display("FAIL areset_strobes: got %b%b want 00", ifa.rx_valid, ifa.frame_err); end
        drive(0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        exp_data[0] = '0; exp_data[1] = '0; exp_cnt[0] = '0; exp_cnt[1] = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back_wrap;
        int xv, xe, xb, ve, vn, ee, en, bn, bo;
        int pulses = 0;
        for (int i = 0; i < 256; i++) begin
            model(0, 10'h2A5, 1'b0, -1, xv, xe, xb);
            run_frame(0, 10'h2A5, 1'b0, -1, 0, ve, vn, ee, en, bn, bo);
            pulses += vn;
            n_cmp++; if (ve !== xv || vn !== 1 || en !== 0) begin n_err++; $display("FAIL b2b%0d_strobe: got edge %0d n %0d err %0d want edge %0d", i, ve, vn, en, xv); end
            n_cmp++; if (ifa.rx_data !== 10'h2A5) begin n_err++; $display("FAIL b2b%0d_data: got %h want 2a5", i, ifa.rx_data); end
            n_cmp++; if (ifa.frame_cnt !== exp_cnt[0]) begin n_err++; $display("FAIL b2b%0d_cnt: got %0d want %0d", i, ifa.frame_cnt, exp_cnt[0]); end
        end
        n_cmp++; if (pulses !== 256) begin n_err++; $display("FAIL b2b_pulses: got %0d want 256", pulses); end
        n_cmp++; if (ifa.frame_cnt !== 8'd0) begin n_err++; $display("FAIL b2b_wrap: got %0d want 0", ifa.frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_glitch();
        test_bad_stop();
        test_abort(21);
        test_abort(46);
        test_bit_cycles_1();
        test_random();
        test_async_reset();
        test_back_to_back_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
